// File: rtl/blk_2bdc2b.sv
// Serial sync-word detector: sliding WIDTH-bit window compared against PATTERN,
// flagging a hit while the window is full and within MAX_ERR bit errors.
module blk_2bdc2b #(
    parameter int unsigned           WIDTH   = 12,
    parameter logic [WIDTH-1:0]      PATTERN = 12'b111000101011,
    parameter int unsigned           MAX_ERR = 2
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_data,
    output logic o_pattern_found
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
    logic [WIDTH-1:0] mismatch;
    logic [CW-1:0]    err_cnt;

    always_comb begin
        shift_reg_d = {shift_reg_q[WIDTH-2:0], i_data};
        fill_cnt_d  = fill_cnt_q;
        if (fill_cnt_q != CW'(WIDTH)) begin
            fill_cnt_d = fill_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            shift_reg_q <= '0;
            fill_cnt_q  <= '0;
        end else begin
            shift_reg_q <= shift_reg_d;
            fill_cnt_q  <= fill_cnt_d;
        end
    end

    // Output decodes registered state only, so reset clears it asynchronously.
    always_comb begin
        mismatch = shift_reg_q ^ PATTERN;
        err_cnt  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            err_cnt = err_cnt + CW'(mismatch[i]);
        end
        o_pattern_found = (fill_cnt_q == CW'(WIDTH)) && (err_cnt <= CW'(MAX_ERR));
    end

endmodule

// File: tb/tb_blk_2bdc2b.sv
// Scoreboard bench for blk_2bdc2b: bit-history reference model feeds an expected
// queue, a negedge monitor pops and compares the detector flag.
module tb_blk_2bdc2b;

    localparam int          W       = 12;
    localparam logic [11:0] PAT     = 12'b111000101011;
    localparam int          MAXE    = 2;

    logic i_clk = 1'b0;
    logic i_resetn = 1'b0;
    logic i_data = 1'b0;
    logic o_pattern_found;

    int n_cmp = 0;
    int n_err = 0;

    logic exp_q[$];
    bit   hist[$];

    blk_2bdc2b #(.WIDTH(12), .PATTERN(12'b111000101011), .MAX_ERR(2)) dut (
        .i_clk          (i_clk),
        .i_resetn       (i_resetn),
        .i_data         (i_data),
        .o_pattern_found(o_pattern_found)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: Hamming distance of the last W received bits to the sync word.
    function automatic logic model_found();
        int errs;
        logic [11:0] pat;
        if (hist.size() < W) return 1'b0;
        pat  = PAT;
        errs = 0;
        for (int i = 0; i < W; i++) begin
            if (hist[hist.size() - W + i] != pat[W - 1 - i]) errs++;
        end
        return (errs <= MAXE);
    endfunction

    task automatic shift_bit(input bit b);
        i_data = b;
        @(posedge i_clk);
        #1;
        hist.push_back(b);
        if (hist.size() > W) void'(hist.pop_front());
        exp_q.push_back(model_found());
    endtask

    task automatic shift_word(input logic [11:0] w);
        for (int i = W - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        #1;
        i_resetn = 1'b0;
        #1;
        check("rst_assert", o_pattern_found, 1'b0);
        hist.delete();
        @(negedge i_clk);
        check("rst_hold", o_pattern_found, 1'b0);
        i_resetn = 1'b1;
        #1;
        check("rst_release", o_pattern_found, 1'b0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge i_clk);
            if (exp_q.size() > 0) check("sb_found", o_pattern_found, exp_q.pop_front());
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        logic [11:0] w;
        bit seq5[$];
        #3;
        check("rst_initial", o_pattern_found, 1'b0);
        do_reset();

        // exact pattern: hit only after the 12th bit
        shift_word(PAT);
        check("exact_hit", o_pattern_found, 1'b1);

        do_reset();
        shift_word(12'b111000101010);
        check("err1_lsb", o_pattern_found, 1'b1);
        do_reset();
        shift_word(12'b111000100011);
        check("err1_bit3", o_pattern_found, 1'b1);
        do_reset();
        shift_word(12'b111000111010);
        check("err2_max", o_pattern_found, 1'b1);
        do_reset();
        shift_word(12'b111000111000);
        check("err3_miss", o_pattern_found, 1'b0);

        // fill gate: 10 bits matching the pattern tail
        do_reset();
        w = PAT;
        for (int i = 9; i >= 0; i--) shift_bit(w[i]);
        check("fill_gate", o_pattern_found, 1'b0);

        // overlapping stream
        do_reset();
        seq5 = '{1,0,1,0, 1,0,1,0,0};
        foreach (seq5[i]) shift_bit(seq5[i]);
        shift_word(PAT);
        shift_bit(1'b1);
        seq5 = '{0,0,0,1,0,1,0,1,1};
        foreach (seq5[i]) shift_bit(seq5[i]);

        // asynchronous reset between edges while matching
        do_reset();
        shift_word(PAT);
        @(negedge i_clk);
        check("pre_midrst", o_pattern_found, 1'b1);
        #2;
        i_resetn = 1'b0;
        #1;
        check("midrst_async", o_pattern_found, 1'b0);
        hist.delete();
        @(negedge i_clk);
        i_resetn = 1'b1;
        for (int i = W - 1; i >= 1; i--) shift_bit(w[i]);
        check("post_rst_11", o_pattern_found, 1'b0);
        shift_bit(w[0]);
        check("post_rst_12", o_pattern_found, 1'b1);

        // randomized: noise interleaved with pattern copies carrying 0..3 flips
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                w = PAT;
                for (int k = $urandom_range(0, 3); k > 0; k--) w[$urandom_range(0, W - 1)] ^= 1'b1;
                shift_word(w);
            end else begin
                for (int k = $urandom_range(1, 8); k > 0; k--) shift_bit(1'($urandom));
            end
            if ($urandom_range(0, 40) == 0) do_reset();
        end

        repeat (4) @(negedge i_clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
